// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready handshakes, carry/overflow flags
// and a count of results accepted by the consumer.
module hack_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] xp_q, xp_d;
    logic [WIDTH-1:0] yp_q, yp_d;
    logic             f_q, f_d;
    logic             no_q, no_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             cy_q, cy_d;
    logic             ov_q, ov_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             s2_adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] x_sel;
    logic [WIDTH-1:0] y_sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] res;

    // Handshake: S2 frees up on output transfer, S1 frees up when it moves into S2.
    always_comb begin
        out_xfer = s2_valid_q & out_ready;
        s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready = ~s1_valid_q | s2_adv;
        in_xfer  = in_valid & in_ready;

        s1_valid_d = s1_valid_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (s2_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end

        count_d = out_xfer ? count_q + CNT_W'(1) : count_q;
    end

    always_comb begin
        x_sel = zx ? '0 : x;
        y_sel = zy ? '0 : y;
        xp_d  = in_xfer ? (nx ? ~x_sel : x_sel) : xp_q;
        yp_d  = in_xfer ? (ny ? ~y_sel : y_sel) : yp_q;
        f_d   = in_xfer ? f  : f_q;
        no_d  = in_xfer ? no : no_q;
    end

    // Carry and overflow describe the adder itself, so they ignore the final inversion.
    always_comb begin
        sum = {1'b0, xp_q} + {1'b0, yp_q};
        r   = f_q ? sum[WIDTH-1:0] : (xp_q & yp_q);
        res = no_q ? ~r : r;

        out_d = out_q;
        zr_d  = zr_q;
        ng_d  = ng_q;
        cy_d  = cy_q;
        ov_d  = ov_q;
        if (s2_adv) begin
            out_d = res;
            zr_d  = (res == '0);
            ng_d  = res[WIDTH-1];
            cy_d  = f_q & sum[WIDTH];
            ov_d  = f_q & (xp_q[WIDTH-1] == yp_q[WIDTH-1]) & (sum[WIDTH-1] != xp_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            xp_q       <= '0;
            yp_q       <= '0;
            f_q        <= 1'b0;
            no_q       <= 1'b0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
            cy_q       <= 1'b0;
            ov_q       <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            xp_q       <= xp_d;
            yp_q       <= yp_d;
            f_q        <= f_d;
            no_q       <= no_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            zr_q       <= zr_d;
            ng_q       <= ng_d;
            cy_q       <= cy_d;
            ov_q       <= ov_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign cy        = cy_q;
    assign ov        = ov_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Directed self-checking bench for hack_alu_pipe: a 16-bit counter instance
// and a 2-bit counter instance share the same stimulus.
module tb_hack_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] x;
    logic [15:0] y;
    logic        zx, nx, zy, ny, f, no;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out;
    logic        zr, ng, cy, ov;
    logic [15:0] op_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [15:0] out2;
    logic        zr2, ng2, cy2, ov2;
    logic [1:0]  op_count2;

    int checks;
    int errors;

    hack_alu_pipe #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zr(zr), .ng(ng), .cy(cy), .ov(ov), .op_count(op_count)
    );

    hack_alu_pipe #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .out_valid(out_valid2), .out_ready(out_ready), .out(out2),
        .zr(zr2), .ng(ng2), .cy(cy2), .ov(ov2), .op_count(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word is packed {zx,nx,zy,ny,f,no}.
    task automatic drive(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c);
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no} = c;
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_hs: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        checks++;
        if (out !== 16'h0 || {zr, ng, cy, ov} !== 4'b0000 || op_count !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_vals: out=%h flags=%b cnt=%0d expected 0", out, {zr, ng, cy, ov}, op_count);
        end
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        do_reset();
        out_ready = 1'b1;
        drive(16'd9, 16'd15, 6'b000010);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_latency: out_valid=%b expected 0 one cycle after accept", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 16'd24 || {zr, ng, cy, ov} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL add: valid=%b out=%h flags=%b expected 1/0018/0000", out_valid, out, {zr, ng, cy, ov});
        end
        step();
        checks++;
        if (op_count !== 16'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_count: cnt=%0d valid=%b expected 1/0", op_count, out_valid);
        end
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        drive(16'd9, 16'd15, 6'b010011);
        step();
        drive(16'd9, 16'd15, 6'b000111);
        step();
        in_valid = 1'b0;
        checks++;
        if (out !== 16'hFFFA || {zr, ng, cy, ov} !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL x_minus_y: out=%h flags=%b expected fffa/0110", out, {zr, ng, cy, ov});
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 16'd6 || {zr, ng, cy, ov} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL y_minus_x: valid=%b out=%h flags=%b expected 1/0006/0000", out_valid, out, {zr, ng, cy, ov});
        end
        drive(16'd9, 16'd15, 6'b000000);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out !== 16'd9 || {zr, ng, cy, ov} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL and: out=%h flags=%b expected 0009/0000", out, {zr, ng, cy, ov});
        end
        step();
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        drive(16'hFFFF, 16'd1, 6'b000010);
        step();
        drive(16'h7FFF, 16'd1, 6'b000010);
        step();
        in_valid = 1'b0;
        checks++;
        if (out !== 16'h0000 || {zr, ng, cy, ov} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL carry_zero: out=%h flags=%b expected 0000/1010", out, {zr, ng, cy, ov});
        end
        step();
        checks++;
        if (out !== 16'h8000 || {zr, ng, cy, ov} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL overflow: out=%h flags=%b expected 8000/0101", out, {zr, ng, cy, ov});
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        drive(16'd1, 16'd2, 6'b000010);
        step();
        drive(16'd10, 16'd20, 6'b000010);
        step();
        drive(16'd100, 16'd200, 6'b000010);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 16'd3) begin
            errors++;
            $display("[TB] FAIL bp_full: in_ready=%b valid=%b out=%0d expected 0/1/3", in_ready, out_valid, out);
        end
        step();
        checks++;
        if (in_ready !== 1'b0 || out !== 16'd3 || op_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL bp_hold: in_ready=%b out=%0d cnt=%0d expected 0/3/0", in_ready, out, op_count);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_ready_comb: in_ready=%b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out !== 16'd30 || op_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL bp_second: valid=%b out=%0d cnt=%0d expected 1/30/1", out_valid, out, op_count);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 16'd300 || op_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL bp_third: valid=%b out=%0d cnt=%0d expected 1/300/2", out_valid, out, op_count);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || op_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL bp_drain: valid=%b cnt=%0d expected 0/3", out_valid, op_count);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(16'd5, 16'd6, 6'b000010);
        step();
        drive(16'd7, 16'd8, 6'b000010);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_fill: valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: valid=%b in_ready=%b cnt=%0d expected 0/1/0", out_valid, in_ready, op_count);
        end
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || op_count !== 16'd0) begin
                errors++;
                $display("[TB] FAIL mid_stale[%0d]: valid=%b cnt=%0d expected 0/0", i, out_valid, op_count);
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [15:0] exp_out [5];
        logic [1:0]  exp_cnt;
        do_reset();
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) exp_out[j] = 16'(j * 3 + 1) + 16'(j + 2);
        for (int k = 1; k <= 7; k++) begin
            if (k <= 5) begin
                drive(16'(k * 3 - 2), 16'(k + 1), 6'b000010);
                #1;
                checks++;
                if (in_ready2 !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL wrap_ready[%0d]: in_ready=%b expected 1", k, in_ready2);
                end
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (k >= 2 && k <= 6) begin
                checks++;
                if (out_valid2 !== 1'b1 || out2 !== exp_out[k-2]) begin
                    errors++;
                    $display("[TB] FAIL wrap_out[%0d]: valid=%b out=%0d expected 1/%0d", k, out_valid2, out2, exp_out[k-2]);
                end
            end
            if (k >= 3) begin
                exp_cnt = 2'((k - 2) % 4);
                checks++;
                if (op_count2 !== exp_cnt) begin
                    errors++;
                    $display("[TB] FAIL wrap_cnt[%0d]: cnt=%0d expected %0d", k, op_count2, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = '0;
        y = '0;
        {zx, nx, zy, ny, f, no} = 6'b000000;
        #7;
        test_reset();
        test_add();
        test_sub();
        test_flags();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_alu_pipe.md
Name: hack_alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational Hack ALU.
- Keeps the six Hack control bits: zx, nx, zy, ny, f, no.
- Adds a WIDTH parameter, valid/ready handshakes on both sides, carry and overflow flags, and a completed-operation counter.
- Sits between the CPU operand-select logic and the writeback path so the ALU can be retimed off the critical path.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/control bundle valid
in_ready  out  1  block can accept a bundle this cycle
x  in  WIDTH  operand x (two's complement)
y  in  WIDTH  operand y (two's complement)
zx  in  1  zero x
nx  in  1  invert x (after zx)
zy  in  1  zero y
ny  in  1  invert y (after zy)
f  in  1  1 = add, 0 = bitwise AND
no  in  1  invert result
out_valid  out  1  result bundle valid
out_ready  in  1  consumer accepts result
out  out  WIDTH  result
zr  out  1  out == 0
ng  out  1  out[WIDTH-1]
cy  out  1  carry out of x'+y' (0 when f=0)
ov  out  1  signed overflow of x'+y' (0 when f=0)
op_count  out  CNT_W  number of results accepted by the consumer, wraps

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without a clock edge):
  - Both stage valid bits clear; out, zr, ng, cy, ov, op_count = 0.
  - out_valid = 0; in_ready = 1 while in reset and after release.
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Stage 1 (S1) on input transfer:
  - x' = zx ? 0 : x, then x' = nx ? ~x' : x'. Same for y' using zy, ny.
  - Registers x', y', f, no; sets s1_valid.
- Stage 2 (S2) on S1 advance:
  - sum = {1'b0,x'} + {1'b0,y'} (WIDTH+1 bits); r = f ? sum[WIDTH-1:0] : x'&y'.
  - Registers out = no ? ~r : r.
  - zr = (out == 0); ng = out[WIDTH-1], both computed on the final (post-no) value.
  - cy = f & sum[WIDTH]; ov = f & (x'[MSB]==y'[MSB]) & (sum[WIDTH-1]!=x'[MSB]). cy and ov are pre-negation and unaffected by no.
  - out_valid = s2_valid.
- Advance rules:
  - s2_adv = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | s2_adv. This is combinational from out_ready; there is no combinational path from in_valid.
  - S2 is cleared on output transfer unless refilled in the same cycle.
  - S1 is cleared on s2_adv unless refilled in the same cycle.
- Latency and throughput:
  - Latency is 2 cycles: a bundle accepted at edge N presents out_valid after edge N+1.
  - Throughput is 1 result per cycle with out_ready held high.
- Backpressure:
  - While out_valid & !out_ready, out, zr, ng, cy and ov hold stable.
  - S1 may still fill once, then in_ready drops.
  - Maximum 2 bundles in flight; no drops and no duplicates; order preserved.
- Simultaneous events: output transfer, S1->S2 move and new input transfer can all occur on the same edge.
- op_count increments by 1 on every output transfer and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: in-flight bundles are discarded, never emitted, and not counted.
- Flag outputs are registered only; there are no combinational paths from x/y to outputs.

Test Plan:
- WIDTH=16, out_ready=1; x=9, y=15, zx..no=000010 -> out=24, zr=0, ng=0, cy=0, ov=0, out_valid 2 cycles after acceptance.
- x=9, y=15, 010011 (x-y) -> out=-6 (16'hFFFA), ng=1, zr=0. Then 000111 (y-x) -> out=6.
- x=16'hFFFF, y=1, 000010 -> out=0, zr=1, cy=1, ov=0. Then x=16'h7FFF, y=1, 000010 -> out=16'h8000, ng=1, ov=1, cy=0.
- Hold out_ready=0 and offer 3 back-to-back bundles -> 2 accepted, in_ready=0, out frozen at the first result. Release out_ready -> 3 results in order on consecutive cycles, op_count=3.
- Fill both stages, pulse rst_n low between clock edges -> out_valid=0, in_ready=1, op_count=0 immediately; no stale result appears after release.
- CNT_W=2, stream 5 bundles with out_ready=1 -> op_count sequence 1,2,3,0,1; full-rate input accepted every cycle.
